hyperbus_arbiter: RTL and testbench

HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

---
 rtl/hyperbus_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_hyperbus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: round-robin front end that lets two requesters share one HyperBus controller.
// Latency: gnt/done/err are registered 1-cycle pulses after the deciding edge; rdat/rvalid and ctl_rrq/ctl_wrq are combinational.
// Backpressure: a requester holds reqN until gntN; requests raised outside IDLE wait, nothing is queued.
//
// Ports:
//   clk, rstn                      sole clock, asynchronous active-low reset
//   reqN/weN/regN/adrN/wdatN       requester N command (level request, held until gntN)
//   gntN/doneN/errN                requester N accept / completion / failure pulses
//   rdatN/rvalidN                  requester N read data, forwarded live from the controller
//   ctl_adr/ctl_dat_o/ctl_reg      latched command toward the controller
//   ctl_rrq/ctl_wrq                read / write request toward the controller
//   ctl_dat_i/ctl_busy/ctl_dvalid  controller read data, busy and data-valid
//   ctl_error                      sticky controller error
//   fault                          arbiter parked in ERROR until reset
module hyperbus_arbiter #(
   parameter int WIDTH         = 8,
   parameter int ISSUE_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rstn,

   input  logic                 req0,
   input  logic                 we0,
   input  logic                 reg0,
   input  logic [31:0]          adr0,
   input  logic [2*WIDTH-1:0]   wdat0,
   output logic                 gnt0,
   output logic [2*WIDTH-1:0]   rdat0,
   output logic                 rvalid0,
   output logic                 done0,
   output logic                 err0,

   input  logic                 req1,
   input  logic                 we1,
   input  logic                 reg1,
   input  logic [31:0]          adr1,
   input  logic [2*WIDTH-1:0]   wdat1,
   output logic                 gnt1,
   output logic [2*WIDTH-1:0]   rdat1,
   output logic                 rvalid1,
   output logic                 done1,
   output logic                 err1,

   output logic [31:0]          ctl_adr,
   output logic [2*WIDTH-1:0]   ctl_dat_o,
   input  logic [2*WIDTH-1:0]   ctl_dat_i,
   output logic                 ctl_reg,
   output logic                 ctl_rrq,
   output logic                 ctl_wrq,
   input  logic                 ctl_busy,
   input  logic                 ctl_dvalid,
   input  logic                 ctl_error,
   output logic                 fault
);

   localparam int DW  = 2 * WIDTH;
   localparam int WDW = (ISSUE_TIMEOUT < 1) ? 1 : $clog2(ISSUE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_ACTIVE = 2'd2,
      S_ERROR  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // r_prio names the requester that wins a tie; it flips away from each winner.
   logic             r_prio;
   logic             r_owner;
   logic             r_we;
   logic             r_reg;
   logic [31:0]      r_adr;
   logic [DW-1:0]    r_wdat;
   logic [WDW-1:0]   r_wdog;
   logic [1:0]       r_gnt;
   logic [1:0]       r_done;
   logic [1:0]       r_err;

   logic             w_pick;
   logic             w_win;
   logic             w_timeout;
   logic [WDW-1:0]   w_wdog_inc;
   logic [1:0]       w_owner_oh;
   logic [1:0]       w_gnt_set;
   logic [1:0]       w_done_set;
   logic [1:0]       w_err_set;

   assign w_pick     = (r_state == S_IDLE) && (req0 || req1);
   // Requester 1 wins when it is alone or when the tie goes its way.
   assign w_win      = req1 && (!req0 || r_prio);
   assign w_wdog_inc = r_wdog + WDW'(1);
   // The cycle that would bring the watchdog to ISSUE_TIMEOUT is the last one allowed.
   assign w_timeout  = (w_wdog_inc == WDW'(ISSUE_TIMEOUT));
   assign w_owner_oh = {r_owner, !r_owner};

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req0 || req1) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ctl_error) begin
               w_state_nxt = S_ERROR;
            end else if (ctl_busy) begin
               w_state_nxt = S_ACTIVE;
            end else if (w_timeout) begin
               w_state_nxt = S_ERROR;
            end
         end
         S_ACTIVE: begin
            // A sticky error outranks the completion seen in the same cycle.
            if (ctl_error) begin
               w_state_nxt = S_ERROR;
            end else if (!ctl_busy) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ERROR: begin
            w_state_nxt = S_ERROR;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      w_gnt_set  = 2'b00;
      w_done_set = 2'b00;
      w_err_set  = 2'b00;
      ctl_rrq    = 1'b0;
      ctl_wrq    = 1'b0;
      rvalid0    = 1'b0;
      rvalid1    = 1'b0;
      fault      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pick) begin
               w_gnt_set = w_win ? 2'b10 : 2'b01;
            end
         end
         S_ISSUE: begin
            ctl_rrq = !r_we;
            ctl_wrq = r_we;
            if (ctl_error || (!ctl_busy && w_timeout)) begin
               w_err_set = w_owner_oh;
            end
         end
         S_ACTIVE: begin
            // The request drops in the very cycle the controller releases busy.
            ctl_rrq = !r_we && ctl_busy;
            ctl_wrq = r_we && ctl_busy;
            rvalid0 = ctl_dvalid && !r_owner;
            rvalid1 = ctl_dvalid && r_owner;
            if (ctl_error) begin
               w_err_set = w_owner_oh;
            end else if (!ctl_busy) begin
               w_done_set = w_owner_oh;
            end
         end
         S_ERROR: begin
            fault = 1'b1;
         end
         default: begin
            fault = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath and pulses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prio  <= 1'b0;
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_reg   <= 1'b0;
         r_adr   <= '0;
         r_wdat  <= '0;
         r_wdog  <= '0;
         r_gnt   <= 2'b00;
         r_done  <= 2'b00;
         r_err   <= 2'b00;
      end else begin
         r_gnt  <= w_gnt_set;
         r_done <= w_done_set;
         r_err  <= w_err_set;
         if (w_pick) begin
            r_owner <= w_win;
            r_prio  <= !w_win;
            r_we    <= w_win ? we1   : we0;
            r_reg   <= w_win ? reg1  : reg0;
            r_adr   <= w_win ? adr1  : adr0;
            r_wdat  <= w_win ? wdat1 : wdat0;
            r_wdog  <= '0;
         end else if ((r_state == S_ISSUE) && !ctl_busy && !ctl_error) begin
            r_wdog <= w_wdog_inc;
         end
      end
   end

   assign gnt0      = r_gnt[0];
   assign gnt1      = r_gnt[1];
   assign done0     = r_done[0];
   assign done1     = r_done[1];
   assign err0      = r_err[0];
   assign err1      = r_err[1];
   assign rdat0     = rvalid0 ? ctl_dat_i : '0;
   assign rdat1     = rvalid1 ? ctl_dat_i : '0;
   assign ctl_adr   = r_adr;
   assign ctl_dat_o = r_wdat;
   assign ctl_reg   = r_reg;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb_hyperbus_arbiter: directed bench with a transaction-level reference model.
// Latency: model predicts registered pulses one cycle after the deciding cycle, combinational outputs live.
// Backpressure: bench requesters hold reqN until the grant; controller stub drives busy/dvalid/error.
module tb_hyperbus_arbiter;

   localparam int WIDTH = 8;
   localparam int DW    = 2 * WIDTH;
   localparam int TMO   = 15;

   logic            clk;
   logic            rstn;
   logic            req0, we0, reg0, req1, we1, reg1;
   logic [31:0]     adr0, adr1;
   logic [DW-1:0]   wdat0, wdat1;
   logic            gnt0, rvalid0, done0, err0, gnt1, rvalid1, done1, err1;
   logic [DW-1:0]   rdat0, rdat1;
   logic [31:0]     ctl_adr;
   logic [DW-1:0]   ctl_dat_o, ctl_dat_i;
   logic            ctl_reg, ctl_rrq, ctl_wrq, ctl_busy, ctl_dvalid, ctl_error, fault;

   hyperbus_arbiter #(.WIDTH(WIDTH), .ISSUE_TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req0), .we0(we0), .reg0(reg0), .adr0(adr0), .wdat0(wdat0),
      .gnt0(gnt0), .rdat0(rdat0), .rvalid0(rvalid0), .done0(done0), .err0(err0),
      .req1(req1), .we1(we1), .reg1(reg1), .adr1(adr1), .wdat1(wdat1),
      .gnt1(gnt1), .rdat1(rdat1), .rvalid1(rvalid1), .done1(done1), .err1(err1),
      .ctl_adr(ctl_adr), .ctl_dat_o(ctl_dat_o), .ctl_dat_i(ctl_dat_i),
      .ctl_reg(ctl_reg), .ctl_rrq(ctl_rrq), .ctl_wrq(ctl_wrq),
      .ctl_busy(ctl_busy), .ctl_dvalid(ctl_dvalid), .ctl_error(ctl_error), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   // The model thinks in transactions: is one in flight, has the controller
   // picked it up yet, and has the arbiter died. Pulses it decides in one
   // cycle are expected on the DUT outputs in the next one.
   bit          m_dead, m_inflight, m_started, m_fav, m_we, m_reg;
   int          m_owner, m_issue;
   logic [31:0] m_adr;
   logic [DW-1:0] m_wdat;
   logic [1:0]  e_gnt, e_done, e_err;

   // observation log used by the literal checks
   int          cyc;
   int          glog[$];
   int          n_done[2], n_err[2], n_rv[2];
   int          g_cyc0, e_cyc0;
   logic [DW-1:0] last_rdat0;
   logic [31:0] last_rrq_adr;
   logic [DW-1:0] last_wrq_dat;

   task automatic model_reset();
      m_dead = 0; m_inflight = 0; m_started = 0; m_fav = 0; m_we = 0; m_reg = 0;
      m_owner = 0; m_issue = 0; m_adr = '0; m_wdat = '0;
      e_gnt = 2'b00; e_done = 2'b00; e_err = 2'b00;
   endtask

   task automatic clr_log();
      glog.delete();
      n_done[0] = 0; n_done[1] = 0; n_err[0] = 0; n_err[1] = 0; n_rv[0] = 0; n_rv[1] = 0;
      g_cyc0 = -1; e_cyc0 = -1; last_rdat0 = '0; last_rrq_adr = '0; last_wrq_dat = '0;
   endtask

   initial begin
      bit   want_rq;
      bit   rv_e0, rv_e1;
      int   w;
      model_reset();
      clr_log();
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rstn) begin
            chk("rst_gnt",   64'({gnt1, gnt0}), 64'(0));
            chk("rst_done",  64'({done1, done0}), 64'(0));
            chk("rst_err",   64'({err1, err0}), 64'(0));
            chk("rst_rvalid", 64'({rvalid1, rvalid0}), 64'(0));
            chk("rst_rdat",  64'({rdat1, rdat0}), 64'(0));
            chk("rst_rq",    64'({ctl_rrq, ctl_wrq, ctl_reg, fault}), 64'(0));
            chk("rst_adr",   64'(ctl_adr), 64'(0));
            chk("rst_dat_o", 64'(ctl_dat_o), 64'(0));
            model_reset();
         end else begin
            want_rq = m_inflight && !(m_started && !ctl_busy);
            rv_e0   = m_inflight && m_started && ctl_dvalid && (m_owner == 0);
            rv_e1   = m_inflight && m_started && ctl_dvalid && (m_owner == 1);
            chk("gnt",     64'({gnt1, gnt0}),   64'(e_gnt));
            chk("done",    64'({done1, done0}), 64'(e_done));
            chk("err",     64'({err1, err0}),   64'(e_err));
            chk("fault",   64'(fault),   64'(m_dead));
            chk("ctl_rrq", 64'(ctl_rrq), 64'(want_rq && !m_we));
            chk("ctl_wrq", 64'(ctl_wrq), 64'(want_rq && m_we));
            chk("ctl_adr", 64'(ctl_adr), 64'(m_adr));
            chk("ctl_dat_o", 64'(ctl_dat_o), 64'(m_wdat));
            chk("ctl_reg", 64'(ctl_reg), 64'(m_reg));
            chk("rvalid0", 64'(rvalid0), 64'(rv_e0));
            chk("rvalid1", 64'(rvalid1), 64'(rv_e1));
            if (rv_e0) chk("rdat0", 64'(rdat0), 64'(ctl_dat_i));
            if (rv_e1) chk("rdat1", 64'(rdat1), 64'(ctl_dat_i));

            // log what the DUT actually did
            if (gnt0) begin glog.push_back(0); g_cyc0 = cyc; end
            if (gnt1) glog.push_back(1);
            if (done0) n_done[0]++;
            if (done1) n_done[1]++;
            if (err0) begin n_err[0]++; e_cyc0 = cyc; end
            if (err1) n_err[1]++;
            if (rvalid0) begin n_rv[0]++; last_rdat0 = rdat0; end
            if (rvalid1) n_rv[1]++;
            if (ctl_rrq) last_rrq_adr = ctl_adr;
            if (ctl_wrq) last_wrq_dat = ctl_dat_o;

            // advance the model across the coming clock edge
            e_gnt = 2'b00; e_done = 2'b00; e_err = 2'b00;
            if (!m_dead) begin
               if (!m_inflight) begin
                  if (req0 || req1) begin
                     w = (req0 && req1) ? (m_fav ? 1 : 0) : (req1 ? 1 : 0);
                     m_owner = w;
                     m_we    = (w == 1) ? we1   : we0;
                     m_reg   = (w == 1) ? reg1  : reg0;
                     m_adr   = (w == 1) ? adr1  : adr0;
                     m_wdat  = (w == 1) ? wdat1 : wdat0;
                     e_gnt[w] = 1'b1;
                     m_fav = (w == 0);
                     m_inflight = 1; m_started = 0; m_issue = 0;
                  end
               end else if (ctl_error) begin
                  e_err[m_owner] = 1'b1; m_dead = 1; m_inflight = 0;
               end else if (!m_started) begin
                  if (ctl_busy) begin
                     m_started = 1;
                  end else begin
                     m_issue++;
                     if (m_issue == TMO) begin
                        e_err[m_owner] = 1'b1; m_dead = 1; m_inflight = 0;
                     end
                  end
               end else if (!ctl_busy) begin
                  e_done[m_owner] = 1'b1; m_inflight = 0;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus helpers
   task automatic wait_ctl(output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (ctl_rrq || ctl_wrq) ok = 1;
      end
      chk("ctl_req_seen", 64'(ok), 64'(1));
   endtask

   // Controller stub: busy for busy_cyc cycles, dvalid on the last dv beats,
   // optional error in the cycle busy falls.
   task automatic run_busy(input int busy_cyc, input int dv, input bit err_fall,
                           input logic [DW-1:0] dbase, input bit drop);
      @(posedge clk); #1;
      if (drop) begin req0 = 0; req1 = 0; end
      for (int i = 0; i < busy_cyc; i++) begin
         ctl_busy   = 1;
         ctl_dvalid = (i >= busy_cyc - dv);
         ctl_dat_i  = dbase + DW'(i);
         @(posedge clk); #1;
      end
      ctl_busy = 0; ctl_dvalid = 0; ctl_error = err_fall;
      @(posedge clk); #1;
      ctl_error = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rstn = 0;
      req0 = 0; req1 = 0; ctl_busy = 0; ctl_dvalid = 0; ctl_error = 0;
      idle(3);
      rstn = 1;
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------ directed tests
   initial begin
      bit ok;
      rstn = 0;
      req0 = 0; we0 = 0; reg0 = 0; adr0 = '0; wdat0 = '0;
      req1 = 0; we1 = 0; reg1 = 0; adr1 = '0; wdat1 = '0;
      ctl_dat_i = '0; ctl_busy = 0; ctl_dvalid = 0; ctl_error = 0;
      idle(3);
      chk("reset_fault", 64'(fault), 64'(0));
      chk("reset_rrq",   64'(ctl_rrq), 64'(0));
      rstn = 1;
      idle(2);

      // single read from requester 0
      clr_log();
      req0 = 1; we0 = 0; reg0 = 0; adr0 = 32'h100; wdat0 = 16'h1234;
      wait_ctl(ok);
      if (ok) run_busy(10, 2, 0, 16'hD000, 1);
      req0 = 0;
      idle(3);
      chk("rd_grants",    64'(glog.size()), 64'(1));
      chk("rd_rrq_adr",   64'(last_rrq_adr), 64'h100);
      chk("rd_beats",     64'(n_rv[0]), 64'(2));
      chk("rd_last_rdat", 64'(last_rdat0), 64'hD009);
      chk("rd_done0",     64'(n_done[0]), 64'(1));
      chk("rd_done1",     64'(n_done[1]), 64'(0));

      // write from requester 1; requester 0 raises and cancels meanwhile
      clr_log();
      req1 = 1; we1 = 1; reg1 = 1; adr1 = 32'h44; wdat1 = 16'hA55A;
      fork
         begin
            wait_ctl(ok);
            if (ok) run_busy(6, 0, 0, 16'h0, 1);
         end
         begin
            idle(4);
            req0 = 1;
            idle(2);
            req0 = 0;
         end
      join
      req1 = 0;
      idle(3);
      chk("wr_grants",  64'(glog.size()), 64'(1));
      chk("wr_dat_o",   64'(last_wrq_dat), 64'hA55A);
      chk("wr_rvalid1", 64'(n_rv[1]), 64'(0));
      chk("wr_done1",   64'(n_done[1]), 64'(1));

      // contention from reset: both held high for four transactions
      do_reset();
      clr_log();
      we0 = 0; reg0 = 0; adr0 = 32'h200;
      we1 = 1; reg1 = 0; adr1 = 32'h300; wdat1 = 16'h1111;
      req0 = 1; req1 = 1;
      for (int k = 0; k < 4; k++) begin
         wait_ctl(ok);
         if (ok) run_busy(3, 1, 0, 16'h5000, k == 3);
      end
      req0 = 0; req1 = 0;
      idle(3);
      chk("ct_grants", 64'(glog.size()), 64'(4));
      if (glog.size() == 4) begin
         chk("ct_order0", 64'(glog[0]), 64'(0));
         chk("ct_order1", 64'(glog[1]), 64'(1));
         chk("ct_order2", 64'(glog[2]), 64'(0));
         chk("ct_order3", 64'(glog[3]), 64'(1));
      end
      chk("ct_done0", 64'(n_done[0]), 64'(2));
      chk("ct_done1", 64'(n_done[1]), 64'(2));

      // controller error in the cycle busy falls
      clr_log();
      req0 = 1; we0 = 0; adr0 = 32'h600;
      wait_ctl(ok);
      if (ok) run_busy(5, 1, 1, 16'h7700, 1);
      idle(1);
      chk("ce_err0",  64'(n_err[0]), 64'(1));
      chk("ce_done0", 64'(n_done[0]), 64'(0));
      chk("ce_fault", 64'(fault), 64'(1));
      clr_log();
      req1 = 1;
      idle(6);
      chk("ce_no_gnt", 64'(glog.size()), 64'(0));
      do_reset();
      chk("ce_rst_fault", 64'(fault), 64'(0));
      chk("ce_rst_adr",   64'(ctl_adr), 64'(0));

      // issue timeout: controller never raises busy
      clr_log();
      req0 = 1; adr0 = 32'h700;
      wait_ctl(ok);
      @(posedge clk); #1;
      req0 = 0;
      for (int i = 0; i < 40 && e_cyc0 < 0; i++) idle(1);
      chk("to_err_seen", 64'(e_cyc0 >= 0), 64'(1));
      chk("to_latency",  64'(e_cyc0 - g_cyc0), 64'(TMO));
      chk("to_fault",    64'(fault), 64'(1));
      clr_log();
      req1 = 1; req0 = 1;
      idle(6);
      chk("to_no_gnt", 64'(glog.size()), 64'(0));

      // reset in the middle of an active transaction
      do_reset();
      clr_log();
      req0 = 1; adr0 = 32'h500;
      wait_ctl(ok);
      @(posedge clk); #1;
      req0 = 0; ctl_busy = 1;
      idle(3);
      rstn = 0; ctl_busy = 0;
      idle(2);
      rstn = 1;
      idle(5);
      chk("mr_no_done", 64'(n_done[0]), 64'(0));
      chk("mr_no_err",  64'(n_err[0]), 64'(0));
      chk("mr_fault",   64'(fault), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
